ex_div_scheduler: RTL and testbench
===================================

// Module: ex_div_scheduler
// PURPOSE
//  Shares the single iterative divider between the two EX-stage issue lines (line1 older, line2 younger).
//  Grants requests in program order, drives the divider's start, operand and abort inputs, and holds per-line
//  quotient/remainder until the EX pair advances. Produces per-line stall terms for the EX allowin logic.
//  Sits between the two EX lane instances and the Div unit; exception flush aborts any division in flight.
// PARAMETERS
//  WIDTH        32   operand/result width
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-high
//  flush_i      in   1      exception flush; aborts and clears everything
//  adv_i        in   1      EX pair advances to MEM this cycle (both lines leave)
//  l1_req_i     in   1      line1 holds a div/mod instruction (level, held until adv_i/flush_i)
//  l1_sign_i    in   1      line1 signed divide
//  l1_dividend_i in  WIDTH  line1 dividend
//  l1_divisor_i in   WIDTH  line1 divisor
//  l2_req_i/l2_sign_i/l2_dividend_i/l2_divisor_i  in  1/1/WIDTH/WIDTH  same, line2
//  div_start_o  out  1      one-cycle start pulse to divider
//  div_sign_o   out  1      granted line's sign
//  div_dividend_o out WIDTH granted line's dividend
//  div_divisor_o out WIDTH  granted line's divisor
//  div_abort_o  out  1      divider abort/reset request (= flush_i)
//  div_done_i   in   1      divider finished (one-cycle pulse)
//  div_quot_i   in   WIDTH  divider quotient, valid with div_done_i
//  div_rem_i    in   WIDTH  divider remainder, valid with div_done_i
//  l1_done_o    out  1      line1 result held
//  l1_quot_o, l1_rem_o  out WIDTH  line1 held results
//  l2_done_o, l2_quot_o, l2_rem_o  out 1/WIDTH/WIDTH  same, line2
//  l1_stall_o   out  1      l1_req_i & ~l1_done_o
//  l2_stall_o   out  1      l2_req_i & ~l2_done_o
//  busy_o       out  1      FSM in RUN
// BEHAVIOUR
//  Reset: state IDLE, owner 0, done flags 0, held results 0; all outputs 0.
//  FSM states: IDLE, RUN (owner reg: 1 = line1, 2 = line2).
//  IDLE grant (comb., only if ~flush_i & ~adv_i): line1 if l1_req_i & ~l1_done; else line2 if l2_req_i & ~l2_done.
//   On grant: div_start_o=1, operands/sign = granted line (mux, comb.); next state RUN, owner latched.
//   Line2 is never granted before line1's pending request completes (program order).
//  RUN: operand outputs keep owner's values; div_start_o=0. On div_done_i: capture quot/rem into owner's regs,
//   set owner done flag, -> IDLE. Next grant possible the following cycle (one bubble between lines).
//  Latency: start at cycle T, div_done_i at T+N -> lX_done_o and results visible at T+N+1.
//  adv_i: clears both done flags and held-valid next edge; suppresses grant that cycle (reqs belong to old pair).
//   adv_i while RUN is a protocol violation (stall terms prevent it); bench asserts it never occurs.
//  flush_i (any state): div_abort_o=1 same cycle, no grant; next edge -> IDLE, owner 0, done flags 0.
//   div_done_i coinciding with flush_i is discarded; held result values need not clear.
//  Divide-by-zero, overflow: results passed through unmodified from divider.
//  Requests without pending div (l1_req_i=0): stall 0; done flags only set by capture.
// TESTING
//  Reset: rst=1 two cycles with reqs active -> all outputs 0, no div_start_o; first grant cycle after rst drops.
//  Line1 only: unsigned 100/7 -> div_start_o 1 cycle, divider done after 33 -> l1_quot_o=14, l1_rem_o=2, l1_stall_o falls.
//  Both: l1 signed -7/2, l2 unsigned 9/3 -> l1 first (quot=-3, rem=-1), l2 start 1 cycle after l1 capture, quot=3 rem=0.
//  Flush mid-RUN cycle 10 -> div_abort_o 1 cycle, no done flags, late div_done_i ignored; re-request restarts cleanly.
//  adv_i with new l1_req_i same cycle -> no start that cycle; start next cycle with new operands.
//  div_done_i and flush_i same cycle -> l1_done_o stays 0, state IDLE.

Source files
------------

// File: rtl/ex_div_scheduler.sv
// ex_div_scheduler: arbitrates the shared iterative divider between the two EX
// issue lines in program order, drives the divider interface, and holds each
// line's quotient/remainder until the EX pair advances to MEM.
//
// state | meaning
// IDLE  | divider free; may grant the oldest line with a pending div/mod
// RUN   | divider busy on behalf of owner (1 = line1, 2 = line2)
module ex_div_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             adv_i,
    input  logic             l1_req_i,
    input  logic             l1_sign_i,
    input  logic [WIDTH-1:0] l1_dividend_i,
    input  logic [WIDTH-1:0] l1_divisor_i,
    input  logic             l2_req_i,
    input  logic             l2_sign_i,
    input  logic [WIDTH-1:0] l2_dividend_i,
    input  logic [WIDTH-1:0] l2_divisor_i,
    output logic             div_start_o,
    output logic             div_sign_o,
    output logic [WIDTH-1:0] div_dividend_o,
    output logic [WIDTH-1:0] div_divisor_o,
    output logic             div_abort_o,
    input  logic             div_done_i,
    input  logic [WIDTH-1:0] div_quot_i,
    input  logic [WIDTH-1:0] div_rem_i,
    output logic             l1_done_o,
    output logic [WIDTH-1:0] l1_quot_o,
    output logic [WIDTH-1:0] l1_rem_o,
    output logic             l2_done_o,
    output logic [WIDTH-1:0] l2_quot_o,
    output logic [WIDTH-1:0] l2_rem_o,
    output logic             l1_stall_o,
    output logic             l2_stall_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] owner;
    logic       l1_done;
    logic       l2_done;
    logic       l1_pend;
    logic       grant_ok;
    logic       grant_l1;
    logic       grant_l2;
    logic       sel_l1;
    logic       sel_l2;

    // Grant decision: line1 always wins while its request is unresolved, so
    // line2 can never overtake it. Advance/flush/reset cycles never grant.
    always_comb begin
        l1_pend  = l1_req_i & ~l1_done;
        grant_ok = ~rst & ~flush_i & ~adv_i & (state == IDLE);
        grant_l1 = grant_ok & l1_pend;
        grant_l2 = grant_ok & ~l1_pend & l2_req_i & ~l2_done;
        sel_l1   = grant_l1 | ((state == RUN) & (owner == 2'd1));
        sel_l2   = grant_l2 | ((state == RUN) & (owner == 2'd2));
    end

    // Divider interface: operands follow the granted line on the start cycle
    // and the owner for the rest of the run; zero when nobody is selected.
    always_comb begin
        div_start_o    = grant_l1 | grant_l2;
        div_abort_o    = flush_i;
        div_sign_o     = 1'b0;
        div_dividend_o = '0;
        div_divisor_o  = '0;
        if (sel_l1) begin
            div_sign_o     = l1_sign_i;
            div_dividend_o = l1_dividend_i;
            div_divisor_o  = l1_divisor_i;
        end else if (sel_l2) begin
            div_sign_o     = l2_sign_i;
            div_dividend_o = l2_dividend_i;
            div_divisor_o  = l2_divisor_i;
        end
    end

    // Status outputs; stalls are masked during reset so the block presents
    // all-zero outputs while held in reset even with requests asserted.
    always_comb begin
        l1_done_o  = l1_done;
        l2_done_o  = l2_done;
        l1_stall_o = ~rst & l1_req_i & ~l1_done;
        l2_stall_o = ~rst & l2_req_i & ~l2_done;
        busy_o     = (state == RUN);
    end

    // Scheduler FSM with owner tracking and per-line result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            l1_done   <= 1'b0;
            l2_done   <= 1'b0;
            l1_quot_o <= '0;
            l1_rem_o  <= '0;
            l2_quot_o <= '0;
            l2_rem_o  <= '0;
        end else if (flush_i) begin
            // A done pulse in the flush cycle is dropped with everything else.
            state   <= IDLE;
            owner   <= 2'd0;
            l1_done <= 1'b0;
            l2_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (adv_i) begin
                        l1_done <= 1'b0;
                        l2_done <= 1'b0;
                    end else if (grant_l1) begin
                        state <= RUN;
                        owner <= 2'd1;
                    end else if (grant_l2) begin
                        state <= RUN;
                        owner <= 2'd2;
                    end
                end
                RUN: begin
                    if (div_done_i) begin
                        if (owner == 2'd1) begin
                            l1_done   <= 1'b1;
                            l1_quot_o <= div_quot_i;
                            l1_rem_o  <= div_rem_i;
                        end else begin
                            l2_done   <= 1'b1;
                            l2_quot_o <= div_quot_i;
                            l2_rem_o  <= div_rem_i;
                        end
                        state <= IDLE;
                        owner <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_scheduler.sv
// tb_ex_div_scheduler: behavioural divider model plus scoreboard for the
// EX-stage divider scheduler.
module tb_ex_div_scheduler;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        adv_i;
    logic        l1_req_i, l1_sign_i;
    logic [31:0] l1_dividend_i, l1_divisor_i;
    logic        l2_req_i, l2_sign_i;
    logic [31:0] l2_dividend_i, l2_divisor_i;
    logic        div_start_o, div_sign_o, div_abort_o;
    logic [31:0] div_dividend_o, div_divisor_o;
    logic        div_done_i;
    logic [31:0] div_quot_i, div_rem_i;
    logic        l1_done_o, l2_done_o;
    logic [31:0] l1_quot_o, l1_rem_o, l2_quot_o, l2_rem_o;
    logic        l1_stall_o, l2_stall_o, busy_o;

    int checks = 0;
    int errors = 0;

    // divider model controls
    logic        model_en;
    int          lat;
    logic        mdl_done, mdl_busy;
    int          mdl_cnt;
    logic [31:0] mdl_q, mdl_r;
    logic        man_done;
    logic [31:0] man_q, man_r;

    typedef struct {
        int          line;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          line;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    assign div_done_i = model_en ? mdl_done : man_done;
    assign div_quot_i = model_en ? mdl_q : man_q;
    assign div_rem_i  = model_en ? mdl_r : man_r;

    ex_div_scheduler #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .adv_i(adv_i),
        .l1_req_i(l1_req_i), .l1_sign_i(l1_sign_i),
        .l1_dividend_i(l1_dividend_i), .l1_divisor_i(l1_divisor_i),
        .l2_req_i(l2_req_i), .l2_sign_i(l2_sign_i),
        .l2_dividend_i(l2_dividend_i), .l2_divisor_i(l2_divisor_i),
        .div_start_o(div_start_o), .div_sign_o(div_sign_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_abort_o(div_abort_o), .div_done_i(div_done_i),
        .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
        .l1_done_o(l1_done_o), .l1_quot_o(l1_quot_o), .l1_rem_o(l1_rem_o),
        .l2_done_o(l2_done_o), .l2_quot_o(l2_quot_o), .l2_rem_o(l2_rem_o),
        .l1_stall_o(l1_stall_o), .l2_stall_o(l2_stall_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // reference divide: zero divisor -> all ones / dividend, signed overflow -> dividend / 0
    task automatic calc(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // divider model: start seen at negedge of T, done pulse sampled at the edge ending T+lat
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (div_abort_o) begin
            mdl_busy = 1'b0;
        end else if (model_en && div_start_o) begin
            calc(div_sign_o, div_dividend_o, div_divisor_o, mdl_q, mdl_r);
            mdl_busy = 1'b1;
            mdl_cnt  = lat;
        end else if (mdl_busy) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mdl_done = 1'b1;
                mdl_busy = 1'b0;
            end
        end
    end

    // scoreboard: pop on each rising done flag; also watch for adv_i during RUN
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    task automatic score(input int line, input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done line=%0d quot=%h rem=%h required=none", line, q, r);
        end else begin
            e = exp_q.pop_front();
            chk("sb_line", 32'(line), 32'(e.line));
            chk("sb_quot", q, e.q);
            chk("sb_rem", r, e.r);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p1 = 1'b0;
            p2 = 1'b0;
        end else begin
            if (l1_done_o && !p1) score(1, l1_quot_o, l1_rem_o);
            if (l2_done_o && !p2) score(2, l2_quot_o, l2_rem_o);
            p1 = l1_done_o;
            p2 = l2_done_o;
            if (adv_i) chk("adv_in_run", 32'(busy_o), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic push(input int line, input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        e.line = line;
        e.q    = q;
        e.r    = r;
        exp_q.push_back(e);
    endtask

    task automatic set_line(input int line, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (line == 1) begin
            l1_req_i = 1'b1; l1_sign_i = s; l1_dividend_i = a; l1_divisor_i = b;
        end else begin
            l2_req_i = 1'b1; l2_sign_i = s; l2_dividend_i = a; l2_divisor_i = b;
        end
    endtask

    task automatic wait_done(input int line, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            samp();
            if ((line == 1) ? l1_done_o : l2_done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout line=%0d actual=no_done required=done", line);
        end
    endtask

    task automatic advance_and_clear();
        step(); adv_i = 1'b1;
        samp(); chk("adv_no_start", 32'(div_start_o), 32'd0);
        step(); adv_i = 1'b0; l1_req_i = 1'b0; l2_req_i = 1'b0;
        samp(); chk("adv_clears_done", 32'({l1_done_o, l2_done_o}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1, 1'b0, 32'd100,         32'd7,          32'd14,         32'd2,  33};
        vecs[1] = '{2, 1'b0, 32'hFFFF_FFFF,   32'd16,         32'h0FFF_FFFF,  32'd15, 4};
        vecs[2] = '{1, 1'b1, 32'd100,         -32'sd7,        -32'sd14,       32'd2,  5};
        vecs[3] = '{2, 1'b1, -32'sd100,       32'd7,          -32'sd14,       -32'sd2, 5};
        vecs[4] = '{1, 1'b0, 32'd5,           32'd0,          32'hFFFF_FFFF,  32'd5,  3};
        vecs[5] = '{2, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  32'd0,  3};

        rst = 1'b1; flush_i = 1'b0; adv_i = 1'b0;
        model_en = 1'b1; lat = 33; man_done = 1'b0; man_q = '0; man_r = '0;
        l1_req_i = 1'b0; l1_sign_i = 1'b0; l1_dividend_i = '0; l1_divisor_i = '0;
        l2_req_i = 1'b0; l2_sign_i = 1'b0; l2_dividend_i = '0; l2_divisor_i = '0;
        set_line(1, 1'b1, -32'sd7, 32'd2);
        set_line(2, 1'b0, 32'd9, 32'd3);

        // reset held two cycles with both requests active
        step(); step();
        samp();
        chk("reset_ctl", 32'({div_start_o, busy_o, l1_done_o, l2_done_o,
                              l1_stall_o, l2_stall_o, div_abort_o, div_sign_o}), 32'd0);
        chk("reset_ops", div_dividend_o | div_divisor_o, 32'd0);
        chk("reset_l1_res", l1_quot_o | l1_rem_o, 32'd0);
        chk("reset_l2_res", l2_quot_o | l2_rem_o, 32'd0);

        // both lines: line1 first, line2 the cycle line1's result appears
        push(1, -32'sd3, -32'sd1);
        push(2, 32'd3, 32'd0);
        step(); rst = 1'b0;
        samp();
        chk("first_grant_start", 32'(div_start_o), 32'd1);
        chk("first_grant_ops", div_dividend_o, -32'sd7);
        chk("first_grant_sign", 32'(div_sign_o), 32'd1);
        chk("both_stall", 32'({l1_stall_o, l2_stall_o}), 32'd3);
        step(); samp();
        chk("run_busy_nostart", 32'({busy_o, div_start_o}), 32'd2);
        chk("run_hold_ops", div_divisor_o, 32'd2);
        wait_done(1, 60);
        chk("l1_stall_fall", 32'(l1_stall_o), 32'd0);
        chk("l2_start_after_l1", 32'(div_start_o), 32'd1);
        chk("l2_ops", div_dividend_o, 32'd9);
        chk("l2_sign", 32'(div_sign_o), 32'd0);
        chk("l2_stall_held", 32'(l2_stall_o), 32'd1);
        wait_done(2, 60);
        chk("l2_stall_fall", 32'(l2_stall_o), 32'd0);
        advance_and_clear();

        // single-line vectors
        for (int i = 0; i < 6; i++) begin
            step();
            lat = vecs[i].lat;
            set_line(vecs[i].line, vecs[i].sign, vecs[i].a, vecs[i].b);
            push(vecs[i].line, vecs[i].q, vecs[i].r);
            samp();
            chk("vec_start", 32'(div_start_o), 32'd1);
            chk("vec_dividend", div_dividend_o, vecs[i].a);
            chk("vec_divisor", div_divisor_o, vecs[i].b);
            chk("vec_sign", 32'(div_sign_o), 32'(vecs[i].sign));
            wait_done(vecs[i].line, vecs[i].lat + 10);
            chk("vec_stall_fall", 32'((vecs[i].line == 1) ? l1_stall_o : l2_stall_o), 32'd0);
            advance_and_clear();
        end

        // flush ten cycles into a run; later stray done is ignored
        step(); lat = 33; set_line(1, 1'b0, 32'd1000, 32'd10);
        samp(); chk("flush_start", 32'(div_start_o), 32'd1);
        repeat (9) step();
        flush_i = 1'b1;
        samp();
        chk("flush_abort", 32'(div_abort_o), 32'd1);
        chk("flush_no_start", 32'(div_start_o), 32'd0);
        step(); flush_i = 1'b0; l1_req_i = 1'b0;
        samp();
        chk("flush_after", 32'({div_abort_o, busy_o, l1_done_o}), 32'd0);
        step(); model_en = 1'b0; man_done = 1'b1; man_q = 32'd77; man_r = 32'd1;
        samp();
        step(); man_done = 1'b0; model_en = 1'b1;
        samp();
        chk("late_done_ignored", 32'({l1_done_o, busy_o}), 32'd0);

        // clean restart after flush
        step(); lat = 6; set_line(1, 1'b0, 32'd20, 32'd6); push(1, 32'd3, 32'd2);
        samp();
        chk("restart_start", 32'(div_start_o), 32'd1);
        chk("restart_ops", div_dividend_o, 32'd20);
        wait_done(1, 20);

        // advance with a new line1 request already present
        step(); adv_i = 1'b1; set_line(1, 1'b0, 32'd81, 32'd9);
        samp(); chk("adv_suppress", 32'(div_start_o), 32'd0);
        step(); adv_i = 1'b0; push(1, 32'd9, 32'd0);
        samp();
        chk("adv_next_start", 32'(div_start_o), 32'd1);
        chk("adv_next_ops", div_dividend_o, 32'd81);
        wait_done(1, 20);
        advance_and_clear();

        // done pulse and flush in the same cycle
        step(); model_en = 1'b0; set_line(1, 1'b0, 32'd3, 32'd1);
        samp(); chk("df_start", 32'(div_start_o), 32'd1);
        step(); step();
        man_done = 1'b1; man_q = 32'd3; man_r = 32'd0; flush_i = 1'b1;
        samp(); chk("df_abort", 32'(div_abort_o), 32'd1);
        step(); man_done = 1'b0; flush_i = 1'b0; l1_req_i = 1'b0; model_en = 1'b1;
        samp(); chk("df_no_done", 32'({l1_done_o, busy_o}), 32'd0);
        step(); samp();
        chk("df_still_idle", 32'({l1_done_o, busy_o, div_start_o}), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
